// File: rtl/udp_rx_port_demux.sv
// udp_rx_port_demux
//   Receive-side Ethernet II / IPv4 / UDP parser. Filters incoming MAC rx
//   frames by destination MAC, destination IP and NUM_CH UDP listen ports,
//   then forwards each accepted payload as one packet on a single output
//   stream tagged with the matched channel index and source IP/port.
//
// Ports
//   axi_tclk, axi_tresetn    clock, asynchronous active-low reset
//   rx_axis_*                8-bit frame stream from MAC (no preamble/FCS)
//   m_axis_*                 8-bit payload stream, tdest = channel index,
//                            tuser = truncated/errored packet (with tlast)
//   m_src_ip, m_src_port     source IP / UDP port of the current packet
//   app_mac, app_ip          local addresses (broadcast also accepted)
//   listen_ports             channel i port at [16i+15:16i], 0 = disabled
//   stat_rx_good/_drop       saturating accepted / rejected frame counters
module udp_rx_port_demux #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int STAT_W = 16
) (
  input  logic                 axi_tclk,
  input  logic                 axi_tresetn,
  input  logic [7:0]           rx_axis_tdata,
  input  logic                 rx_axis_tvalid,
  input  logic                 rx_axis_tlast,
  input  logic                 rx_axis_tuser,
  output logic                 rx_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CH_W-1:0]      m_axis_tdest,
  input  logic                 m_axis_tready,
  output logic [31:0]          m_src_ip,
  output logic [15:0]          m_src_port,
  input  logic [47:0]          app_mac,
  input  logic [31:0]          app_ip,
  input  logic [NUM_CH*16-1:0] listen_ports,
  output logic [STAT_W-1:0]    stat_rx_good,
  output logic [STAT_W-1:0]    stat_rx_drop
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  state_t            state_reg;
  logic [5:0]        byte_cnt_reg;
  logic              mac_uni_reg, mac_bc_reg, ip_uni_reg, ip_bc_reg;
  logic [7:0]        hi_reg;          // high byte of the 16-bit field in flight
  logic [CH_W-1:0]   ch_reg;
  logic [15:0]       rem_reg;
  logic [31:0]       src_ip_sh_reg;
  logic [15:0]       src_port_sh_reg;
  logic              first_reg;
  logic [7:0]        m_data_reg;
  logic              m_valid_reg, m_last_reg, m_user_reg;
  logic [CH_W-1:0]   m_dest_reg;
  logic [31:0]       m_ip_reg;
  logic [15:0]       m_port_reg;
  logic [STAT_W-1:0] good_reg, drop_reg;

  logic              rx_fire, out_ready, in_hdr;
  logic [5:0]        idx;
  logic [7:0]        exp_byte;
  logic              mac_uni_now, mac_bc_now, ip_uni_now, ip_bc_now;
  logic [NUM_CH-1:0] port_hit;
  logic              ch_hit;
  logic [CH_W-1:0]   ch_sel;
  logic [15:0]       udp_len;
  logic              hdr_fail, good_inc, drop_inc;

  assign out_ready      = !m_valid_reg || m_axis_tready;
  assign rx_axis_tready = (state_reg == PAYLOAD) ? out_ready : 1'b1;
  assign rx_fire        = rx_axis_tvalid && rx_axis_tready;
  assign in_hdr         = (state_reg == IDLE) || (state_reg == HDR);
  // The byte taken in IDLE is header offset 0.
  assign idx            = (state_reg == IDLE) ? 6'd0 : byte_cnt_reg;
  assign udp_len        = {hi_reg, rx_axis_tdata};

  always_comb begin
    exp_byte = 8'h00;
    case (idx)
      6'd0:  exp_byte = app_mac[47:40];
      6'd1:  exp_byte = app_mac[39:32];
      6'd2:  exp_byte = app_mac[31:24];
      6'd3:  exp_byte = app_mac[23:16];
      6'd4:  exp_byte = app_mac[15:8];
      6'd5:  exp_byte = app_mac[7:0];
      6'd30: exp_byte = app_ip[31:24];
      6'd31: exp_byte = app_ip[23:16];
      6'd32: exp_byte = app_ip[15:8];
      6'd33: exp_byte = app_ip[7:0];
      default: exp_byte = 8'h00;
    endcase
  end

  // Unicast and broadcast matches are tracked separately byte by byte so a
  // mix of the two (e.g. ff:ff:00:...) is still rejected.
  assign mac_uni_now = ((idx == 6'd0)  ? 1'b1 : mac_uni_reg) && (rx_axis_tdata == exp_byte);
  assign mac_bc_now  = ((idx == 6'd0)  ? 1'b1 : mac_bc_reg)  && (rx_axis_tdata == 8'hFF);
  assign ip_uni_now  = ((idx == 6'd30) ? 1'b1 : ip_uni_reg)  && (rx_axis_tdata == exp_byte);
  assign ip_bc_now   = ((idx == 6'd30) ? 1'b1 : ip_bc_reg)   && (rx_axis_tdata == 8'hFF);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_port
      assign port_hit[gi] = (listen_ports[16*gi +: 16] != 16'd0) &&
                            (listen_ports[16*gi +: 16] == udp_len);
    end
  endgenerate

  // Lowest channel index wins when several channels listen on one port.
  always_comb begin
    ch_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (port_hit[i]) ch_sel = CH_W'(i);
    end
  end
  assign ch_hit = |port_hit;

  always_comb begin
    hdr_fail = 1'b0;
    if (idx <= 6'd5)                       hdr_fail = !(mac_uni_now || mac_bc_now);
    else if (idx == 6'd12)                 hdr_fail = (rx_axis_tdata != 8'h08);
    else if (idx == 6'd13)                 hdr_fail = (rx_axis_tdata != 8'h00);
    else if (idx == 6'd14)                 hdr_fail = (rx_axis_tdata != 8'h45);
    else if (idx == 6'd20)                 hdr_fail = (rx_axis_tdata[5:0] != 6'd0);
    else if (idx == 6'd21)                 hdr_fail = (rx_axis_tdata != 8'h00);
    else if (idx == 6'd23)                 hdr_fail = (rx_axis_tdata != 8'd17);
    else if (idx >= 6'd30 && idx <= 6'd33) hdr_fail = !(ip_uni_now || ip_bc_now);
    else if (idx == 6'd37)                 hdr_fail = !ch_hit;
    else if (idx == 6'd39)                 hdr_fail = (udp_len <= 16'd8);
  end

  // A frame ending before the header is complete is also a rejected frame.
  assign drop_inc = in_hdr && rx_fire && (hdr_fail || (rx_axis_tlast && idx != 6'd41));
  assign good_inc = (state_reg == PAYLOAD) && rx_fire && (rem_reg == 16'd1);

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= '0;
      mac_uni_reg     <= 1'b0;
      mac_bc_reg      <= 1'b0;
      ip_uni_reg      <= 1'b0;
      ip_bc_reg       <= 1'b0;
      hi_reg          <= '0;
      ch_reg          <= '0;
      rem_reg         <= '0;
      src_ip_sh_reg   <= '0;
      src_port_sh_reg <= '0;
      first_reg       <= 1'b0;
      m_data_reg      <= '0;
      m_valid_reg     <= 1'b0;
      m_last_reg      <= 1'b0;
      m_user_reg      <= 1'b0;
      m_dest_reg      <= '0;
      m_ip_reg        <= '0;
      m_port_reg      <= '0;
    end else begin
      if (m_valid_reg && m_axis_tready) m_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, HDR: begin
          if (rx_fire) begin
            mac_uni_reg  <= mac_uni_now;
            mac_bc_reg   <= mac_bc_now;
            ip_uni_reg   <= ip_uni_now;
            ip_bc_reg    <= ip_bc_now;
            hi_reg       <= rx_axis_tdata;
            byte_cnt_reg <= idx + 6'd1;
            if (idx >= 6'd26 && idx <= 6'd29) src_ip_sh_reg   <= {src_ip_sh_reg[23:0], rx_axis_tdata};
            if (idx == 6'd34 || idx == 6'd35) src_port_sh_reg <= {src_port_sh_reg[7:0], rx_axis_tdata};
            if (idx == 6'd37) ch_reg  <= ch_sel;
            if (idx == 6'd39) rem_reg <= udp_len - 16'd8;
            if (hdr_fail)                state_reg <= rx_axis_tlast ? IDLE : DROP;
            else if (rx_axis_tlast)      state_reg <= IDLE;
            else if (idx == 6'd41) begin
              state_reg <= PAYLOAD;
              first_reg <= 1'b1;
            end else                     state_reg <= HDR;
          end
        end
        PAYLOAD: begin
          // rx_fire here implies the output register is free this cycle.
          if (rx_fire) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= rx_axis_tdata;
            m_dest_reg  <= ch_reg;
            rem_reg     <= rem_reg - 16'd1;
            first_reg   <= 1'b0;
            if (first_reg) begin
              m_ip_reg   <= src_ip_sh_reg;
              m_port_reg <= src_port_sh_reg;
            end
            if (rem_reg == 16'd1) begin
              m_last_reg <= 1'b1;
              m_user_reg <= rx_axis_tlast && rx_axis_tuser;
              // Trailing Ethernet padding is swallowed in DROP.
              state_reg  <= rx_axis_tlast ? IDLE : DROP;
            end else if (rx_axis_tlast) begin
              m_last_reg <= 1'b1;
              m_user_reg <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              m_last_reg <= 1'b0;
              m_user_reg <= 1'b0;
            end
          end
        end
        DROP: begin
          if (rx_fire && rx_axis_tlast) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      good_reg <= '0;
      drop_reg <= '0;
    end else begin
      if (good_inc && good_reg != {STAT_W{1'b1}}) good_reg <= good_reg + 1'b1;
      if (drop_inc && drop_reg != {STAT_W{1'b1}}) drop_reg <= drop_reg + 1'b1;
    end
  end

  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tlast  = m_last_reg;
  assign m_axis_tuser  = m_user_reg;
  assign m_axis_tdest  = m_dest_reg;
  assign m_src_ip      = m_ip_reg;
  assign m_src_port    = m_port_reg;
  assign stat_rx_good  = good_reg;
  assign stat_rx_drop  = drop_reg;

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Directed testbench for udp_rx_port_demux: builds frames byte by byte,
// collects output beats in a queue and compares against expected values.
module tb_udp_rx_port_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid, rx_tlast, rx_tuser, rx_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic [1:0]  m_tdest;
  logic        m_tready;
  logic [31:0] m_src_ip;
  logic [15:0] m_src_port;
  logic [47:0] app_mac;
  logic [31:0] app_ip;
  logic [63:0] listen_ports;
  logic [15:0] stat_good, stat_drop;

  always #5 clk = ~clk;

  udp_rx_port_demux #(.NUM_CH(4), .CH_W(2), .STAT_W(16)) dut (
    .axi_tclk(clk), .axi_tresetn(rst_n),
    .rx_axis_tdata(rx_tdata), .rx_axis_tvalid(rx_tvalid), .rx_axis_tlast(rx_tlast),
    .rx_axis_tuser(rx_tuser), .rx_axis_tready(rx_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tdest(m_tdest), .m_axis_tready(m_tready),
    .m_src_ip(m_src_ip), .m_src_port(m_src_port),
    .app_mac(app_mac), .app_ip(app_ip), .listen_ports(listen_ports),
    .stat_rx_good(stat_good), .stat_rx_drop(stat_drop)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic        u;
    logic [1:0]  t;
    logic [31:0] ip;
    logic [15:0] port;
  } beat_t;

  beat_t      out_q[$];
  logic [7:0] frame_q[$];
  int         mode = 0;   // 0 always ready, 1 toggling, 2 never ready
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pay_byte(input int i);
    return 8'(i * 13 + 5);
  endfunction

  // Output side: ready changes just after the edge, beats are recorded on
  // the falling edge when valid and ready are both high.
  always begin
    @(posedge clk);
    #1;
    case (mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (m_tvalid && m_tready)
      out_q.push_back('{m_tdata, m_tlast, m_tuser, m_tdest, m_src_ip, m_src_port});
  end

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                             input logic [15:0] frag, input logic [7:0] proto,
                             input logic [31:0] sip, input logic [31:0] dip,
                             input logic [15:0] sport, input logic [15:0] dport,
                             input logic [15:0] ulen, input int npay, input int total);
    logic [15:0] iplen;
    iplen = ulen + 16'd20;
    frame_q.delete();
    for (int i = 5; i >= 0; i--) frame_q.push_back(dmac[8*i +: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(8'(8'h0A + i));
    frame_q.push_back(etype[15:8]); frame_q.push_back(etype[7:0]);
    frame_q.push_back(8'h45);       frame_q.push_back(8'h00);
    frame_q.push_back(iplen[15:8]); frame_q.push_back(iplen[7:0]);
    frame_q.push_back(8'h00);       frame_q.push_back(8'h00);
    frame_q.push_back(frag[15:8]);  frame_q.push_back(frag[7:0]);
    frame_q.push_back(8'd64);       frame_q.push_back(proto);
    frame_q.push_back(8'h00);       frame_q.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frame_q.push_back(sip[8*i +: 8]);
    for (int i = 3; i >= 0; i--) frame_q.push_back(dip[8*i +: 8]);
    frame_q.push_back(sport[15:8]); frame_q.push_back(sport[7:0]);
    frame_q.push_back(dport[15:8]); frame_q.push_back(dport[7:0]);
    frame_q.push_back(ulen[15:8]);  frame_q.push_back(ulen[7:0]);
    frame_q.push_back(8'h00);       frame_q.push_back(8'h00);
    for (int i = 0; i < npay; i++) frame_q.push_back(pay_byte(i));
    while (frame_q.size() < total) frame_q.push_back(8'h00);
  endtask

  // Sends frame_q[first +: count]; caller is aligned just after a rising edge.
  task automatic send(input int first, input int count, input bit with_last, input bit err);
    for (int i = 0; i < count; i++) begin
      int w;
      bit acc;
      w = 0;
      acc = 1'b0;
      rx_tdata  = frame_q[first + i];
      rx_tvalid = 1'b1;
      rx_tlast  = with_last && (i == count - 1);
      rx_tuser  = err && rx_tlast;
      while (!acc) begin
        @(negedge clk);
        acc = rx_tready;
        @(posedge clk);
        #1;
        w++;
        if (!acc && w > 1000) begin
          check("rx_tready_timeout", 64'd0, 64'd1);
          rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
          return;
        end
      end
    end
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int w;
    w = 0;
    while (out_q.size() < n && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (6) begin @(posedge clk); #1; end
    check("beat_count", 64'(out_q.size()), 64'(n));
  endtask

  task automatic check_pkt(input int n, input logic [1:0] dest, input logic [31:0] sip,
                           input logic [15:0] sport, input bit euser);
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      check("data",  64'(out_q[i].d),    64'(pay_byte(i)));
      check("tlast", 64'(out_q[i].l),    64'(i == n - 1));
      check("tuser", 64'(out_q[i].u),    64'((i == n - 1) && euser));
      check("tdest", 64'(out_q[i].t),    64'(dest));
      check("src_ip", 64'(out_q[i].ip),  64'(sip));
      check("src_port", 64'(out_q[i].port), 64'(sport));
    end
    out_q.delete();
  endtask

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [31:0] IP    = 32'hC0A8_010A;
  localparam logic [31:0] SIP   = 32'h0A00_0001;
  localparam logic [47:0] BCMAC = 48'hFFFF_FFFF_FFFF;

  initial begin
    rst_n = 1'b0;
    rx_tdata = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    m_tready = 1'b1;
    app_mac = MAC;
    app_ip  = IP;
    listen_ports = {16'd6000, 16'd5000, 16'd6000, 16'd1000};
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_meta", 64'({m_tlast, m_tuser, m_tdest}), 64'd0);
    check("rst_src", 64'({m_src_ip, m_src_port}), 64'd0);
    check("rst_stats", 64'({stat_good, stat_drop}), 64'd0);
    check("rst_rx_tready", 64'(rx_tready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unicast, port 5000 -> channel 2, 4 payload bytes.
    build_frame(MAC, 16'h0800, 16'h4000, 8'd17, SIP, IP, 16'd1234, 16'd5000, 16'd12, 4, 46);
    send(0, frame_q.size(), 1'b1, 1'b0);
    wait_out(4);
    check_pkt(4, 2'd2, SIP, 16'd1234, 1'b0);
    check("good_after_1", 64'(stat_good), 64'd1);

    // 18 payload bytes, padded to 64, errored padding, toggling ready.
    mode = 1;
    build_frame(MAC, 16'h0800, 16'h0000, 8'd17, 32'h0B0C0D0E, IP, 16'd777, 16'd5000, 16'd26, 18, 64);
    send(0, frame_q.size(), 1'b1, 1'b1);
    wait_out(18);
    check_pkt(18, 2'd2, 32'h0B0C0D0E, 16'd777, 1'b0);
    check("drop_after_pad", 64'(stat_drop), 64'd0);
    check("good_after_2", 64'(stat_good), 64'd2);
    mode = 0;

    // Five rejected frames.
    build_frame(MAC, 16'h0806, 16'h0000, 8'd17, SIP, IP, 16'd1, 16'd5000, 16'd12, 4, 46);
    send(0, frame_q.size(), 1'b1, 1'b0);
    build_frame(MAC, 16'h0800, 16'h0000, 8'd6, SIP, IP, 16'd1, 16'd5000, 16'd12, 4, 46);
    send(0, frame_q.size(), 1'b1, 1'b0);
    build_frame(MAC, 16'h0800, 16'h0000, 8'd17, SIP, 32'hC0A8010B, 16'd1, 16'd5000, 16'd12, 4, 46);
    send(0, frame_q.size(), 1'b1, 1'b0);
    build_frame(MAC, 16'h0800, 16'h0000, 8'd17, SIP, IP, 16'd1, 16'd7777, 16'd12, 4, 46);
    send(0, frame_q.size(), 1'b1, 1'b0);
    build_frame(MAC, 16'h0800, 16'h0001, 8'd17, SIP, IP, 16'd1, 16'd5000, 16'd12, 4, 46);
    send(0, frame_q.size(), 1'b1, 1'b0);
    wait_out(0);
    check("drop_after_bad", 64'(stat_drop), 64'd5);
    check("good_after_bad", 64'(stat_good), 64'd2);

    // Broadcast MAC and IP, port on channels 1 and 3 -> channel 1.
    build_frame(BCMAC, 16'h0800, 16'h0000, 8'd17, 32'h01020304, 32'hFFFFFFFF, 16'd53, 16'd6000, 16'd10, 2, 44);
    send(0, frame_q.size(), 1'b1, 1'b0);
    wait_out(2);
    check_pkt(2, 2'd1, 32'h01020304, 16'd53, 1'b0);
    check("good_after_bc", 64'(stat_good), 64'd3);

    // UDP length 100 but frame ends after 10 payload bytes.
    build_frame(MAC, 16'h0800, 16'h0000, 8'd17, SIP, IP, 16'd99, 16'd1000, 16'd100, 10, 52);
    send(0, frame_q.size(), 1'b1, 1'b0);
    wait_out(10);
    check_pkt(10, 2'd0, SIP, 16'd99, 1'b1);

    // Reset mid-payload with the output register stalled.
    mode = 2;
    build_frame(MAC, 16'h0800, 16'h0000, 8'd17, SIP, IP, 16'd42, 16'd5000, 16'd16, 8, 50);
    send(0, 43, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("stalled_valid", 64'(m_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_out", 64'({m_tdata, m_tlast, m_tuser, m_tdest}), 64'd0);
    check("midrst_src", 64'({m_src_ip, m_src_port}), 64'd0);
    check("midrst_stats", 64'({stat_good, stat_drop}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode = 0;
    @(posedge clk); #1;
    out_q.delete();
    send(43, 7, 1'b1, 1'b0);   // remainder begins with 0x12: bad MAC, dropped
    build_frame(MAC, 16'h0800, 16'h0000, 8'd17, 32'hAC100001, IP, 16'd4321, 16'd1000, 16'd13, 5, 47);
    send(0, frame_q.size(), 1'b1, 1'b0);
    wait_out(5);
    check_pkt(5, 2'd0, 32'hAC100001, 16'd4321, 1'b0);
    check("post_rst_good", 64'(stat_good), 64'd1);
    check("post_rst_drop", 64'(stat_drop), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
